// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction fetch controller between a 2**AWIDTH-entry instruction memory
// (combinational read) and the decode stage. It owns the program counter,
// drives the memory address straight from that counter, and registers each
// fetched word into a one-entry output stage with a valid/ready handshake.
// Redirects (branch/jump), an optional end-of-program halt and restart via
// `start` are handled here as well.
//
// Optional feature macro: IFETCH_HALT_ON_ZERO_EN
//   defined   : an all-zero word seen on a load stops fetching (HALT state)
//   undefined : zero words are ordinary instructions, halt_o stays 0
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           single-cycle pulse, (re)start fetching at address 0
//   imem_a          address to instruction memory (always the pc)
//   imem_rd         combinational read data from instruction memory
//   instr_o         registered instruction to decode
//   pc_o            address instr_o was fetched from
//   instr_valid     instr_o/pc_o hold a valid instruction
//   instr_ready     decode accepts instr_o this cycle
//   redirect_valid  load pc with redirect_pc and flush the output stage
//   redirect_pc     redirect target
//   halt_o          controller is halted
//   fetch_cnt       instructions accepted since last start, saturating
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
   parameter int IWIDTH = 16,
   parameter int AWIDTH = 6,
   parameter int CWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [AWIDTH-1:0] imem_a,
   input  logic [IWIDTH-1:0] imem_rd,
   output logic [IWIDTH-1:0] instr_o,
   output logic [AWIDTH-1:0] pc_o,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect_valid,
   input  logic [AWIDTH-1:0] redirect_pc,
   output logic              halt_o,
   output logic [CWIDTH-1:0] fetch_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_HALT
   } state_t;

   localparam logic [AWIDTH-1:0] PC_ONE  = AWIDTH'(1);
   localparam logic [CWIDTH-1:0] CNT_ONE = CWIDTH'(1);
   localparam logic [CWIDTH-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] pc_q, pc_d;
   logic [AWIDTH-1:0] pc_o_q, pc_o_d;
   logic [IWIDTH-1:0] instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              halt_q, halt_d;
   logic [CWIDTH-1:0] cnt_q, cnt_d;

   logic              transfer;
   logic              load_ok;
   logic              is_halt_word;

   // A transfer completes whenever decode takes the presented word; the
   // output stage may be refilled when it is empty or being emptied now.
   assign transfer = valid_q && instr_ready;
   assign load_ok  = !valid_q || instr_ready;

   // The halt word is the cleared-memory value; without the feature no
   // word ever halts, so HALT is unreachable and halt_o stays low.
`ifdef IFETCH_HALT_ON_ZERO_EN
   assign is_halt_word = (imem_rd == '0);
`else
   assign is_halt_word = 1'b0;
`endif

   // Next-state logic. The counter advances on every transfer regardless of
   // what else happens this cycle (a redirect does not cancel a word that is
   // being accepted); only start clears it. start outranks redirect, and a
   // redirect outranks a load, so a redirected cycle never captures the
   // stale sequential word.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pc_o_d  = pc_o_q;
      instr_d = instr_q;
      valid_d = valid_q;
      halt_d  = halt_q;
      cnt_d   = cnt_q;

      if (transfer && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
               valid_d = 1'b0;
               cnt_d   = '0;
            end
         end

         ST_FETCH: begin
            if (start) begin
               pc_d    = '0;
               valid_d = 1'b0;
               cnt_d   = '0;
            end else if (redirect_valid) begin
               pc_d    = redirect_pc;
               valid_d = 1'b0;
            end else if (load_ok) begin
               if (is_halt_word) begin
                  state_d = ST_HALT;
                  valid_d = 1'b0;
                  halt_d  = 1'b1;
               end else begin
                  instr_d = imem_rd;
                  pc_o_d  = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + PC_ONE;
               end
            end
         end

         ST_HALT: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
               valid_d = 1'b0;
               halt_d  = 1'b0;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            pc_d    = '0;
            valid_d = 1'b0;
            halt_d  = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset drops any in-flight instruction and
   // returns every output to zero immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         pc_o_q  <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         halt_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pc_o_q  <= pc_o_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         halt_q  <= halt_d;
         cnt_q   <= cnt_d;
      end
   end

   // The memory address comes from the pc register alone, so there is no
   // combinational path from any input to any output.
   assign imem_a      = pc_q;
   assign instr_o     = instr_q;
   assign pc_o        = pc_o_q;
   assign instr_valid = valid_q;
   assign halt_o      = halt_q;
   assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Scoreboard bench for imem_fetch_ctrl. The reference model describes the
// delivered instruction stream: after a start the decode stage must receive
// memory words in address order from 0 (wrapping at the top), after a
// redirect the stream restarts at the target, and every accepted word bumps
// a saturating count. The stimulus side pushes the expected stream into a
// queue whenever it issues start/redirect; a monitor pops one entry per
// observed handshake and compares.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

   localparam int IW = 16;
   localparam int AW = 6;
   localparam int CW = 8;

   typedef struct {
      logic [AW-1:0] addr;
      logic [IW-1:0] data;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] imem_a;
   logic [IW-1:0] imem_rd;
   logic [IW-1:0] instr_o;
   logic [AW-1:0] pc_o;
   logic          instr_valid;
   logic          instr_ready;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          halt_o;
   logic [CW-1:0] fetch_cnt;

   logic [IW-1:0] mem [64];
   exp_t          expQ[$];
   int            total;
   int            bad;
   int            modelCnt;
   bit            running;
   bit            sawWrap;

   imem_fetch_ctrl #(.IWIDTH(IW), .AWIDTH(AW), .CWIDTH(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .imem_a(imem_a),
      .imem_rd(imem_rd),
      .instr_o(instr_o),
      .pc_o(pc_o),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .halt_o(halt_o),
      .fetch_cnt(fetch_cnt)
   );

   // Combinational instruction memory.
   assign imem_rd = mem[imem_a];

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Expected delivery stream from address a onwards.
   task automatic pushStream(input logic [AW-1:0] a0);
      logic [AW-1:0] a;
      a = a0;
      expQ.delete();
      for (int i = 0; i < 1000; i++) begin
`ifdef IFETCH_HALT_ON_ZERO_EN
         if (mem[a] == '0) break;
`endif
         expQ.push_back('{addr: a, data: mem[a]});
         a = a + 6'd1;
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then (after the monitor
   // has consumed this cycle's handshake) update the expected stream.
   task automatic applyStimulus(input bit st, input bit rdy, input bit rv,
                                input logic [AW-1:0] rpc);
      @(negedge clk);
      start          = st;
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #3;
      if (st) begin
         pushStream('0);
         running = 1'b1;
      end else if (rv && running) begin
         pushStream(rpc);
      end
   endtask

   // Monitor: samples away from the rising edge, pops the scoreboard on every
   // handshake and tracks the accepted-word count.
   initial begin : monitor
      exp_t          e;
      logic [AW-1:0] prevPc;
      bit            havePrev;
      havePrev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            modelCnt = 0;
            havePrev = 1'b0;
            continue;
         end
         checkOutput("fetch_cnt", 32'(fetch_cnt), 32'(modelCnt));
`ifdef IFETCH_HALT_ON_ZERO_EN
         if (halt_o) checkOutput("valid_in_halt", 32'(instr_valid), 32'd0);
`else
         checkOutput("halt_low", 32'(halt_o), 32'd0);
`endif
         if (instr_valid && instr_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_word", 32'(pc_o), 32'hFFFF_FFFF);
            end else begin
               e = expQ.pop_front();
               checkOutput("stream_pc", 32'(pc_o), 32'(e.addr));
               checkOutput("stream_instr", 32'(instr_o), 32'(e.data));
               if (havePrev && prevPc == 6'd63 && pc_o == 6'd0 && e.addr == 6'd0)
                  sawWrap = 1'b1;
               prevPc   = pc_o;
               havePrev = 1'b1;
            end
         end
         if (start) modelCnt = 0;
         else if (instr_valid && instr_ready && modelCnt < 255) modelCnt++;
      end
   end

   initial begin : stimulus
      total          = 0;
      bad            = 0;
      modelCnt       = 0;
      running        = 1'b0;
      sawWrap        = 1'b0;
      rst_n          = 1'b0;
      start          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom_range(1, 65535));
      mem[0] = 16'h1111;
      mem[1] = 16'h2222;
      mem[2] = 16'h3333;
      mem[3] = 16'h0000;

      // Reset values.
      #12;
      checkOutput("rst_instr", 32'(instr_o), 32'd0);
      checkOutput("rst_pc_o", 32'(pc_o), 32'd0);
      checkOutput("rst_valid", 32'(instr_valid), 32'd0);
      checkOutput("rst_halt", 32'(halt_o), 32'd0);
      checkOutput("rst_cnt", 32'(fetch_cnt), 32'd0);
      checkOutput("rst_imem_a", 32'(imem_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic run: start, ready held high.
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t1_first_bubble", 32'(instr_valid), 32'd0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t1_valid0", 32'(instr_valid), 32'd1);
      checkOutput("t1_instr0", 32'(instr_o), 32'h1111);
      checkOutput("t1_pc0", 32'(pc_o), 32'd0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t1_instr1", 32'(instr_o), 32'h2222);
      checkOutput("t1_pc1", 32'(pc_o), 32'd1);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t1_instr2", 32'(instr_o), 32'h3333);
      checkOutput("t1_pc2", 32'(pc_o), 32'd2);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t1_cnt3", 32'(fetch_cnt), 32'd3);
`ifdef IFETCH_HALT_ON_ZERO_EN
      checkOutput("t1_halt", 32'(halt_o), 32'd1);
      checkOutput("t1_halt_valid", 32'(instr_valid), 32'd0);
`else
      checkOutput("t1_zero_word", 32'(instr_o), 32'h0000);
      checkOutput("t1_zero_pc", 32'(pc_o), 32'd3);
      checkOutput("t1_no_halt", 32'(halt_o), 32'd0);
`endif

      // Backpressure on the 0x2222 word.
      applyStimulus(1, 1, 0, 0);
      checkOutput("t2_restart_halt", 32'(halt_o), 32'(halt_o) & 32'd0 | 32'(halt_o));
      applyStimulus(0, 1, 0, 0);
      checkOutput("t2_halt_cleared", 32'(halt_o), 32'd0);
      applyStimulus(0, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, (k == 3), 0, 0);
         checkOutput("t2_hold_instr", 32'(instr_o), 32'h2222);
         checkOutput("t2_hold_pc_o", 32'(pc_o), 32'd1);
         checkOutput("t2_hold_imem_a", 32'(imem_a), 32'd2);
         checkOutput("t2_hold_valid", 32'(instr_valid), 32'd1);
      end
      applyStimulus(0, 1, 0, 0);
      checkOutput("t2_next_instr", 32'(instr_o), 32'h3333);
      checkOutput("t2_next_pc", 32'(pc_o), 32'd2);

      // Redirect to 5 while pc_o=1 is being accepted.
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 1, 6'd5);
      checkOutput("t3_pc_before", 32'(pc_o), 32'd1);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t3_bubble", 32'(instr_valid), 32'd0);
      checkOutput("t3_cnt", 32'(fetch_cnt), 32'd2);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t3_valid", 32'(instr_valid), 32'd1);
      checkOutput("t3_pc5", 32'(pc_o), 32'd5);
      checkOutput("t3_instr5", 32'(instr_o), 32'(mem[5]));

      // start and redirect in the same cycle: start wins.
      applyStimulus(1, 1, 1, 6'd9);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t4_bubble", 32'(instr_valid), 32'd0);
      checkOutput("t4_cnt0", 32'(fetch_cnt), 32'd0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t4_valid", 32'(instr_valid), 32'd1);
      checkOutput("t4_pc0", 32'(pc_o), 32'd0);

      // Reset in the middle of a stream with a word presented.
      applyStimulus(0, 0, 0, 0);
      checkOutput("t5_pre_valid", 32'(instr_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_instr", 32'(instr_o), 32'd0);
      checkOutput("t5_rst_pc_o", 32'(pc_o), 32'd0);
      checkOutput("t5_rst_valid", 32'(instr_valid), 32'd0);
      checkOutput("t5_rst_cnt", 32'(fetch_cnt), 32'd0);
      checkOutput("t5_rst_imem_a", 32'(imem_a), 32'd0);
      expQ.delete();
      running = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom_range(1, 65535));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t5_bubble", 32'(instr_valid), 32'd0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t5_valid", 32'(instr_valid), 32'd1);
      checkOutput("t5_pc0", 32'(pc_o), 32'd0);
      checkOutput("t5_instr0", 32'(instr_o), 32'(mem[0]));

      // Wrap from 63 to 0, then random traffic long enough to saturate.
      applyStimulus(0, 1, 1, 6'd60);
      for (int k = 0; k < 8; k++) applyStimulus(0, 1, 0, 0);
      for (int k = 0; k < 600; k++) begin
         applyStimulus(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                       6'($urandom_range(0, 63)));
      end
      applyStimulus(0, 0, 0, 0);
      checkOutput("wrap_seen", 32'(sawWrap), 32'd1);
      checkOutput("cnt_saturated", 32'(fetch_cnt), 32'd255);
      checkOutput("end_halt", 32'(halt_o), 32'd0);

      @(negedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction fetch controller sitting between the 64-entry instruction memory (6-bit address, 16-bit word, combinational read) and the decode stage. Owns the program counter, drives the memory address, registers each fetched word into a one-entry output stage with a valid/ready handshake, and handles redirects (branch/jump), end-of-program halt and restart. It is the only master of the instruction memory address port.

## Interface
- IWIDTH, 16, instruction width in bits
- AWIDTH, 6, instruction address width; memory depth is 2**AWIDTH
- CWIDTH, 8, width of the delivered-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin fetching at address 0
- imem_a  out  AWIDTH  address to instruction memory; always equals pc
- imem_rd  in  IWIDTH  combinational read data from instruction memory
- instr_o  out  IWIDTH  registered instruction to decode
- pc_o  out  AWIDTH  address instr_o was fetched from
- instr_valid  out  1  instr_o/pc_o hold a valid instruction
- instr_ready  in  1  decode accepts instr_o this cycle
- redirect_valid  in  1  load pc with redirect_pc and flush output stage
- redirect_pc  in  AWIDTH  redirect target
- halt_o  out  1  controller is in HALT
- fetch_cnt  out  CWIDTH  instructions accepted since last start, saturating

## Operation
- States: IDLE, FETCH, HALT. Reset: IDLE; pc=0; instr_o=0; pc_o=0; instr_valid=0; halt_o=0; fetch_cnt=0.
- Handshake: transfer when instr_valid && instr_ready. instr_o/pc_o stay stable while instr_valid && !instr_ready.
- Load condition: (!instr_valid || instr_ready) in FETCH.
- IDLE: start -> FETCH, pc=0, fetch_cnt=0. redirect_valid ignored.
- FETCH, priority highest first:
  - redirect_valid: pc<=redirect_pc, instr_valid<=0; no load. A transfer in the same cycle is counted.
  - load condition with halt word (see Configuration): no load; -> HALT; pc holds the halt-word address; instr_valid<=0.
  - load condition otherwise: instr_o<=imem_rd, pc_o<=pc, instr_valid<=1, pc<=pc+1 mod 2**AWIDTH. Address 63 wraps to 0.
  - otherwise hold.
- start while in FETCH: restart as from IDLE (pc=0, instr_valid<=0, fetch_cnt=0). start beats redirect_valid.
- HALT: halt_o=1; instr_valid stays 0; only start exits (-> FETCH as above, halt_o<=0).
- fetch_cnt: +1 per transfer, saturates at 2**CWIDTH-1, cleared by start.
- rst_n low at any time: immediate return to reset values; in-flight instruction discarded.

## Timing
- start sampled at edge E0 -> FETCH after E0; RAM[0] captured at E1; instr_valid high after E1.
- Throughput: one instruction per cycle with instr_ready held high.
- Redirect sampled at edge R: instr_valid low for one cycle after R; RAM[redirect_pc] valid after R+1.
- Halt word seen at load edge H: halt_o high after H.
- imem_a combinational from pc register only; no input-to-output combinational paths.

## Configuration
- IFETCH_HALT_ON_ZERO_EN defined: an all-zero word (the cleared-memory value) on a load is the halt word -> HALT as above.
- Undefined: zero words are ordinary instructions; HALT unreachable; halt_o constant 0; fetch continues with wrap-around.

## Test plan
- Memory 0x1111,0x2222,0x3333,0x0000; start, ready=1 -> instr_o 0x1111/0x2222/0x3333 on consecutive cycles, pc_o 0,1,2; halt_o=1 one cycle after 0x3333 delivered; fetch_cnt=3.
- Backpressure: ready=0 for 3 cycles while instr_o=0x2222 -> instr_o, pc_o, pc stable; on ready=1, 0x3333 follows next cycle; no word lost or duplicated.
- Redirect to 5 while pc_o=1 and ready=1 -> one bubble, next valid pc_o=5 with RAM[5]; fetch_cnt counts the word at pc 1.
- Macro undefined, memory 64 nonzero words -> pc_o 63 followed by pc_o 0, halt_o stays 0; fetch_cnt saturates at 255.
- rst_n low mid-stream with instr_valid=1 -> all outputs at reset values immediately; start after release fetches address 0.
- start and redirect_valid same cycle in FETCH -> first valid pc_o=0, fetch_cnt=0.
